// File: rtl/ahb_master_ctrl.sv
// rtl/ahb_master_ctrl.sv - single-transfer AHB-Lite master driven by a register-bank command
// Issues one NONSEQ word transfer per accepted start and reports done/err/timeout.
module ahb_master_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        hresetn,
  input  logic        start,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        timeout,
  output logic [31:0] rdata,
  output logic        rd_valid,
  output logic [31:0] haddr,
  output logic [1:0]  htrans,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [31:0] hwdata,
  input  logic [31:0] hrdata,
  input  logic        hready,
  input  logic        hresp
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_NONSEQ = 2'b10;

  // Counter is wide enough to hold TIMEOUT itself, never narrower than 5 bits.
  localparam int CW = ($clog2(TIMEOUT + 1) > 5) ? $clog2(TIMEOUT + 1) : 5;
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [31:0]   haddr_q, haddr_d;
  logic [31:0]   hwdata_q, hwdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [1:0]    htrans_q, htrans_d;
  logic          hwrite_q, hwrite_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rd_valid_q, rd_valid_d;
  logic          timeout_q, timeout_d;
  logic          wait_expired;

  assign cnt_inc      = cnt_q + 1'b1;
  assign wait_expired = (cnt_inc == TO_VAL);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    haddr_d    = haddr_q;
    hwdata_d   = hwdata_q;
    rdata_d    = rdata_q;
    htrans_d   = htrans_q;
    hwrite_d   = hwrite_q;
    timeout_d  = timeout_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    rd_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        htrans_d = TR_IDLE;
        cnt_d    = '0;
        if (start) begin
          haddr_d   = cmd_addr;
          hwrite_d  = cmd_write;
          hwdata_d  = cmd_wdata;
          timeout_d = 1'b0;
          htrans_d  = TR_NONSEQ;
          state_d   = S_ADDR;
        end
      end
      S_ADDR: begin
        if (hready) begin
          htrans_d = TR_IDLE;
          cnt_d    = '0;
          state_d  = S_DATA;
        end else if (wait_expired) begin
          htrans_d  = TR_IDLE;
          cnt_d     = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_DATA: begin
        if (hresp) begin
          // An ERROR seen with hready already high skips the second ERR cycle.
          cnt_d   = '0;
          state_d = hready ? S_IDLE : S_ERR;
          err_d   = hready;
        end else if (hready) begin
          cnt_d      = '0;
          done_d     = 1'b1;
          rd_valid_d = ~hwrite_q;
          if (!hwrite_q) begin
            rdata_d = hrdata;
          end
          state_d = S_IDLE;
        end else if (wait_expired) begin
          cnt_d     = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      S_ERR: begin
        if (hready) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (wait_expired) begin
          cnt_d     = '0;
          err_d     = 1'b1;
          timeout_d = 1'b1;
          state_d   = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        htrans_d = TR_IDLE;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      haddr_q    <= '0;
      hwdata_q   <= '0;
      rdata_q    <= '0;
      htrans_q   <= TR_IDLE;
      hwrite_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      rdata_q    <= rdata_d;
      htrans_q   <= htrans_d;
      hwrite_q   <= hwrite_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      timeout_q  <= timeout_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;
  assign timeout  = timeout_q;
  assign rdata    = rdata_q;
  assign rd_valid = rd_valid_q;
  assign haddr    = haddr_q;
  assign htrans   = htrans_q;
  assign hwrite   = hwrite_q;
  assign hsize    = 3'b010;
  assign hwdata   = hwdata_q;

endmodule
